// File: rtl/imem_loader.sv
// Byte-stream program loader: takes a 16-bit big-endian length header and then that many
// big-endian 32-bit words, writes them to instruction memory, and holds the CPU in reset meanwhile.
module imem_loader #(
    parameter logic [31:0] TEXT_BASE = 32'h0000_3000,
    parameter int          DEPTH     = 1024,
    parameter int          TIMEOUT   = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        restart,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count,
    output logic [31:0] checksum
);
    // state  | meaning
    // HDR_HI | waiting for length[15:8]; never times out
    // HDR_LO | waiting for length[7:0]
    // DATA   | assembling words, MSB first
    // DONE   | image complete, CPU released one cycle after the last write
    // ERROR  | oversize header or inter-byte timeout
    typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, DONE, ERROR} state_t;

    localparam int            IW        = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
    localparam logic [IW-1:0] IDLE_ONE  = IW'(1);
    localparam logic [16:0]   DEPTH_W   = 17'(DEPTH);

    state_t        state;
    logic [7:0]    len_hi;
    logic [15:0]   length;
    logic [1:0]    byte_idx;
    logic [23:0]   shift;
    logic [IW-1:0] idle;

    logic        accept;
    logic [15:0] hdr_len;
    logic [31:0] word;

    assign accept  = in_valid && in_ready;
    assign hdr_len = {len_hi, in_data};
    assign word    = {shift, in_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HDR_HI;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= TEXT_BASE;
            imem_wdata <= 32'h0;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= 16'h0;
            checksum   <= 32'h0;
            len_hi     <= 8'h0;
            length     <= 16'h0;
            byte_idx   <= 2'd0;
            shift      <= 24'h0;
            idle       <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                HDR_HI: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        len_hi <= in_data;
                        idle   <= '0;
                        state  <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (accept) begin
                        idle   <= '0;
                        length <= hdr_len;
                        if (hdr_len == 16'h0) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                            cpu_rst  <= 1'b0;
                        end else if ({1'b0, hdr_len} > DEPTH_W) begin
                            state    <= ERROR;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end else if (idle == IDLE_LAST) begin
                        state    <= ERROR;
                        in_ready <= 1'b0;
                        error    <= 1'b1;
                    end else begin
                        idle <= idle + IDLE_ONE;
                    end
                end
                DATA: begin
                    if (accept) begin
                        idle     <= '0;
                        byte_idx <= byte_idx + 2'd1;
                        shift    <= {shift[15:0], in_data};
                        if (byte_idx == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= word;
                            imem_addr  <= TEXT_BASE + {14'h0, word_count, 2'b00};
                            word_count <= word_count + 16'd1;
                            checksum   <= checksum ^ word;
                            if (word_count + 16'd1 == length) begin
                                state    <= DONE;
                                in_ready <= 1'b0;
                            end
                        end
                    end else if (idle == IDLE_LAST) begin
                        state    <= ERROR;
                        in_ready <= 1'b0;
                        error    <= 1'b1;
                    end else begin
                        idle <= idle + IDLE_ONE;
                    end
                end
                DONE, ERROR: begin
                    // Release is deferred to here so it lands one cycle after the final write strobe.
                    if (state == DONE) begin
                        done    <= 1'b1;
                        cpu_rst <= 1'b0;
                    end
                    if (restart) begin
                        state      <= HDR_HI;
                        in_ready   <= 1'b1;
                        cpu_rst    <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        word_count <= 16'h0;
                        checksum   <= 32'h0;
                        byte_idx   <= 2'd0;
                        idle       <= '0;
                    end
                end
                default: state <= HDR_HI;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good images, gapped stream, oversize header,
// inter-byte timeout, empty image, restart handling and mid-load reset.
module tb_imem_loader;
    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h0;
    logic        restart = 1'b0;
    logic        in_ready, imem_we, cpu_rst, done, error;
    logic [31:0] imem_addr, imem_wdata, checksum;
    logic [15:0] word_count;

    imem_loader #(.TEXT_BASE(32'h0000_3000), .DEPTH(1024), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .restart(restart), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst), .done(done), .error(error), .word_count(word_count), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;
    int wr_total = 0;
    int base;
    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];

    // Write log, sampled mid-cycle after each rising edge.
    always @(posedge clk) begin
        #2;
        if (imem_we === 1'b1 && wr_total < 64) begin
            wr_addr[wr_total] = imem_addr;
            wr_data[wr_total] = imem_wdata;
            wr_total = wr_total + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n == 200) check("ready_wait", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], gap);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    logic [31:0] w0, w1;

    initial begin
        w0 = 32'h3C01_1234;
        w1 = 32'h3421_5678;

        // reset values
        @(negedge clk);
        check("rst_we", {31'h0, imem_we}, 32'h0);
        check("rst_addr", imem_addr, 32'h0000_3000);
        check("rst_wdata", imem_wdata, 32'h0);
        check("rst_cpu_rst", {31'h0, cpu_rst}, 32'h1);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_error", {31'h0, error}, 32'h0);
        check("rst_wc", {16'h0, word_count}, 32'h0);
        check("rst_cs", checksum, 32'h0);
        rst = 1'b0;
        check("rst_ready_first", {31'h0, in_ready}, 32'h0);
        @(negedge clk);
        check("ready_after_rst", {31'h0, in_ready}, 32'h1);

        // two-word image, back to back
        base = wr_total;
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(w0, 0);
        send_word(w1, 0);
        check("t1_we_last", {31'h0, imem_we}, 32'h1);
        check("t1_addr_last", imem_addr, 32'h0000_3004);
        check("t1_wdata_last", imem_wdata, w1);
        check("t1_wc_in_write", {16'h0, word_count}, 32'h2);
        check("t1_done_not_yet", {31'h0, done}, 32'h0);
        check("t1_cpu_rst_held", {31'h0, cpu_rst}, 32'h1);
        @(negedge clk);
        check("t1_done", {31'h0, done}, 32'h1);
        check("t1_cpu_rst_low", {31'h0, cpu_rst}, 32'h0);
        check("t1_we_off", {31'h0, imem_we}, 32'h0);
        check("t1_ready_low", {31'h0, in_ready}, 32'h0);
        check("t1_nwr", wr_total - base, 32'd2);
        check("t1_addr0", wr_addr[base], 32'h0000_3000);
        check("t1_data0", wr_data[base], w0);
        check("t1_addr1", wr_addr[base+1], 32'h0000_3004);
        check("t1_data1", wr_data[base+1], w1);
        check("t1_cs", checksum, w0 ^ w1);
        check("t1_wc", {16'h0, word_count}, 32'h2);

        // restart clears the load state
        pulse_restart();
        check("rs_done", {31'h0, done}, 32'h0);
        check("rs_cpu_rst", {31'h0, cpu_rst}, 32'h1);
        check("rs_wc", {16'h0, word_count}, 32'h0);
        check("rs_cs", checksum, 32'h0);
        check("rs_ready", {31'h0, in_ready}, 32'h1);

        // same image with gaps; a restart pulse mid-load must be ignored
        base = wr_total;
        send_byte(8'h00, $urandom_range(0, 5));
        send_byte(8'h02, $urandom_range(0, 5));
        send_byte(w0[31:24], $urandom_range(0, 5));
        send_byte(w0[23:16], $urandom_range(0, 5));
        send_byte(w0[15:8], $urandom_range(0, 5));
        send_byte(w0[7:0], $urandom_range(0, 5));
        pulse_restart();
        send_byte(w1[31:24], $urandom_range(0, 5));
        send_byte(w1[23:16], $urandom_range(0, 5));
        send_byte(w1[15:8], $urandom_range(0, 5));
        send_byte(w1[7:0], 0);
        repeat (2) @(negedge clk);
        check("t2_nwr", wr_total - base, 32'd2);
        check("t2_addr0", wr_addr[base], 32'h0000_3000);
        check("t2_data0", wr_data[base], w0);
        check("t2_addr1", wr_addr[base+1], 32'h0000_3004);
        check("t2_data1", wr_data[base+1], w1);
        check("t2_cs", checksum, w0 ^ w1);
        check("t2_error", {31'h0, error}, 32'h0);
        check("t2_done", {31'h0, done}, 32'h1);

        // oversize header 0x0401
        pulse_restart();
        base = wr_total;
        send_byte(8'h04, 0);
        send_byte(8'h01, 0);
        check("t3_error", {31'h0, error}, 32'h1);
        check("t3_cpu_rst", {31'h0, cpu_rst}, 32'h1);
        check("t3_ready", {31'h0, in_ready}, 32'h0);
        repeat (3) @(negedge clk);
        check("t3_done", {31'h0, done}, 32'h0);
        check("t3_nwr", wr_total - base, 32'd0);

        // timeout after 5 data bytes of a 3-word load
        pulse_restart();
        check("t4_error_cleared", {31'h0, error}, 32'h0);
        base = wr_total;
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_word(32'hAABB_CCDD, 0);
        send_byte(8'h11, 0);
        repeat (TO - 1) @(negedge clk);
        check("t4_no_error_yet", {31'h0, error}, 32'h0);
        @(negedge clk);
        check("t4_error", {31'h0, error}, 32'h1);
        check("t4_wc", {16'h0, word_count}, 32'h1);
        check("t4_cs", checksum, 32'hAABB_CCDD);
        check("t4_cpu_rst", {31'h0, cpu_rst}, 32'h1);
        check("t4_nwr", wr_total - base, 32'd1);
        pulse_restart();
        check("t4_rs_error", {31'h0, error}, 32'h0);
        check("t4_rs_wc", {16'h0, word_count}, 32'h0);
        base = wr_total;
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(32'hDEAD_BEEF, 0);
        @(negedge clk);
        check("t4b_nwr", wr_total - base, 32'd1);
        check("t4b_addr", wr_addr[base], 32'h0000_3000);
        check("t4b_data", wr_data[base], 32'hDEAD_BEEF);
        check("t4b_done", {31'h0, done}, 32'h1);
        check("t4b_error", {31'h0, error}, 32'h0);

        // empty image
        pulse_restart();
        base = wr_total;
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("t5_done", {31'h0, done}, 32'h1);
        check("t5_cpu_rst", {31'h0, cpu_rst}, 32'h0);
        repeat (2) @(negedge clk);
        check("t5_nwr", wr_total - base, 32'd0);

        // reset in the middle of the second word
        pulse_restart();
        base = wr_total;
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(32'h0102_0304, 0);
        send_byte(8'h05, 0);
        send_byte(8'h06, 0);
        rst = 1'b1;
        #1;
        check("t6_rst_we", {31'h0, imem_we}, 32'h0);
        check("t6_rst_addr", imem_addr, 32'h0000_3000);
        check("t6_rst_wdata", imem_wdata, 32'h0);
        check("t6_rst_cpu_rst", {31'h0, cpu_rst}, 32'h1);
        check("t6_rst_wc", {16'h0, word_count}, 32'h0);
        check("t6_rst_cs", checksum, 32'h0);
        check("t6_rst_ready", {31'h0, in_ready}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("t6_nwr_partial", wr_total - base, 32'd1);
        base = wr_total;
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(32'hCAFE_F00D, 0);
        @(negedge clk);
        check("t6b_nwr", wr_total - base, 32'd1);
        check("t6b_addr", wr_addr[base], 32'h0000_3000);
        check("t6b_data", wr_data[base], 32'hCAFE_F00D);
        check("t6b_done", {31'h0, done}, 32'h1);
        check("t6b_cs", checksum, 32'hCAFE_F00D);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
